// File: rtl/ps2_key_state_decoder_pkg.sv
// Shared PS/2 byte codes for the scan-code decoder: prefix bytes and the
// keyboard response bytes that never carry key information.
package ps2_key_state_decoder_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  localparam logic [7:0] PS2_RSP_ERR0   = 8'h00;
  localparam logic [7:0] PS2_RSP_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_RSP_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RSP_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RSP_RESEND = 8'hFE;
  localparam logic [7:0] PS2_RSP_ERR1   = 8'hFF;

  // Keyboard housekeeping bytes that arrive in IDLE and must not become keys.
  function automatic logic is_ignored(input logic [7:0] b);
    return b inside {PS2_RSP_ERR0, PS2_RSP_BAT_OK, PS2_RSP_ECHO,
                     PS2_RSP_ACK, PS2_RSP_RESEND, PS2_RSP_ERR1};
  endfunction

endpackage

// File: rtl/ps2_prefix_timer.sv
// Idle-cycle counter used to abandon a half-received prefix sequence.
// Saturates at TIMEOUT_CYCLES; o_expired stays high until cleared.
module ps2_prefix_timer #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] r_count;

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != LIMIT)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_expired = (r_count == LIMIT);

endmodule

// File: rtl/ps2_key_state_decoder.sv
// Turns PS/2 make/break byte sequences into a 512-bit held-key vector plus a
// one-cycle change strobe carrying the index {extended, scan_code}.
module ps2_key_state_decoder
  import ps2_key_state_decoder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int PAUSE_SKIP     = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   rx_byte,
  input  logic         rx_valid,
  input  logic         rx_err,
  output logic [511:0] key_down,
  output logic [8:0]   last_change,
  output logic         key_valid
);

  localparam int SKIP_W = $clog2(PAUSE_SKIP + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK,
    S_SKIP
  } state_t;

  state_t            r_state, w_next_state;
  logic [SKIP_W-1:0] r_skip, w_next_skip;
  logic [511:0]      r_key_down;
  logic [8:0]        r_last_change;
  logic              r_key_valid;

  logic       w_expired;
  logic       w_make;
  logic       w_break;
  logic [8:0] w_index;

  ps2_prefix_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_prefix_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (rx_valid | rx_err),
    .i_enable (1'b1),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_skip  <= '0;
    end else begin
      r_state <= w_next_state;
      r_skip  <= w_next_skip;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    w_next_state = r_state;
    w_next_skip  = r_skip;
    w_make       = 1'b0;
    w_break      = 1'b0;
    w_index      = {1'b0, rx_byte};

    if (rx_err) begin
      w_next_state = S_IDLE;
    end else if (rx_valid) begin
      unique case (r_state)
        S_IDLE: begin
          if (rx_byte == PS2_EXT) begin
            w_next_state = S_EXT;
          end else if (rx_byte == PS2_BRK) begin
            w_next_state = S_BRK;
          end else if (rx_byte == PS2_PAUSE) begin
            w_next_state = S_SKIP;
            w_next_skip  = SKIP_W'(PAUSE_SKIP);
          end else if (!is_ignored(rx_byte)) begin
            w_make = 1'b1;
          end
        end
        S_EXT: begin
          w_index = {1'b1, rx_byte};
          // Repeated E0/E1 here is fake-shift padding; stay waiting for the code.
          if (rx_byte == PS2_BRK) begin
            w_next_state = S_EXT_BRK;
          end else if ((rx_byte != PS2_EXT) && (rx_byte != PS2_PAUSE)) begin
            w_make       = 1'b1;
            w_next_state = S_IDLE;
          end
        end
        S_BRK: begin
          w_break      = 1'b1;
          w_next_state = S_IDLE;
        end
        S_EXT_BRK: begin
          w_index      = {1'b1, rx_byte};
          w_break      = 1'b1;
          w_next_state = S_IDLE;
        end
        S_SKIP: begin
          w_next_skip = r_skip - SKIP_W'(1);
          if (r_skip <= SKIP_W'(1)) begin
            w_next_state = S_IDLE;
          end
        end
        default: w_next_state = S_IDLE;
      endcase
    end else if (w_expired && (r_state != S_IDLE)) begin
      w_next_state = S_IDLE;
    end
  end

  // Typematic repeats and breaks of unheld keys fall through without a pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the key vector is plain flops, not RAM, so reset clears it in one cycle.
      r_key_down    <= '0;
      r_last_change <= '0;
      r_key_valid   <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      if (w_make && !r_key_down[w_index]) begin
        r_key_down[w_index] <= 1'b1;
        r_last_change       <= w_index;
        r_key_valid         <= 1'b1;
      end else if (w_break && r_key_down[w_index]) begin
        r_key_down[w_index] <= 1'b0;
        r_last_change       <= w_index;
        r_key_valid         <= 1'b1;
      end
    end
  end

  assign key_down    = r_key_down;
  assign last_change = r_last_change;
  assign key_valid   = r_key_valid;

endmodule

// File: tb/tb_ps2_key_state_decoder.sv
// Self-checking bench for ps2_key_state_decoder: directed vector table, hand
// sequences for timeout/error/reset, and random byte streams against a model.
module tb_ps2_key_state_decoder;

  localparam int T_OUT = 16;
  localparam int SKIPN = 7;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   rx_byte;
  logic         rx_valid;
  logic         rx_err;
  logic [511:0] key_down;
  logic [8:0]   last_change;
  logic         key_valid;

  ps2_key_state_decoder #(
    .TIMEOUT_CYCLES(T_OUT),
    .PAUSE_SKIP    (SKIPN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .rx_err     (rx_err),
    .key_down   (key_down),
    .last_change(last_change),
    .key_valid  (key_valid)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: pending-prefix mode, bytes left to skip, idle-cycle age.
  localparam int M_IDLE = 0, M_EXT = 1, M_BRK = 2, M_EXT_BRK = 3, M_SKIP = 4;
  logic [511:0] m_keys;
  logic [8:0]   m_lc;
  logic         m_kv;
  int           m_mode, m_skip, m_age;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_keys = '0; m_lc = '0; m_kv = 1'b0;
    m_mode = M_IDLE; m_skip = 0; m_age = 0;
  endtask

  task automatic model_key(input bit make, input logic [8:0] k);
    if (make != m_keys[k]) begin
      m_keys[k] = make;
      m_lc = k;
      m_kv = 1'b1;
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    case (m_mode)
      M_IDLE:
        if (b == 8'hE0) m_mode = M_EXT;
        else if (b == 8'hF0) m_mode = M_BRK;
        else if (b == 8'hE1) begin m_mode = M_SKIP; m_skip = SKIPN; end
        else if (!(b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF})) model_key(1, {1'b0, b});
      M_EXT:
        if (b == 8'hF0) m_mode = M_EXT_BRK;
        else if (b != 8'hE0 && b != 8'hE1) begin model_key(1, {1'b1, b}); m_mode = M_IDLE; end
      M_BRK:     begin model_key(0, {1'b0, b}); m_mode = M_IDLE; end
      M_EXT_BRK: begin model_key(0, {1'b1, b}); m_mode = M_IDLE; end
      default: begin
        m_skip--;
        if (m_skip == 0) m_mode = M_IDLE;
      end
    endcase
  endtask

  task automatic model_cycle(input logic v, input logic [7:0] b, input logic e);
    m_kv = 1'b0;
    if (e) begin
      m_mode = M_IDLE; m_age = 0;
    end else if (v) begin
      m_age = 0;
      model_byte(b);
    end else begin
      if (m_mode != M_IDLE && m_age >= T_OUT) m_mode = M_IDLE;
      if (m_age < T_OUT) m_age++;
    end
  endtask

  // One clock: drive on the falling edge, DUT samples on the rising edge,
  // outputs compared with the model on the next falling edge.
  task automatic step(input logic v, input logic [7:0] b, input logic e);
    rx_valid = v; rx_byte = b; rx_err = e;
    model_cycle(v, b, e);
    @(negedge clk);
    check("model_key_valid",   512'(key_valid),   512'(m_kv));
    check("model_last_change", 512'(last_change), 512'(m_lc));
    check("model_key_down",    key_down,          m_keys);
  endtask

  task automatic do_reset();
    rst = 1'b1; rx_valid = 1'b0; rx_err = 1'b0; rx_byte = 8'h00;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    check("reset_key_down",    key_down,          '0);
    check("reset_last_change", 512'(last_change), '0);
    check("reset_key_valid",   512'(key_valid),   '0);
  endtask

  typedef struct {
    logic       v;
    logic [7:0] b;
    logic       kv;
    logic [8:0] lc;
    logic [8:0] idx;
    logic       bitv;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic v, input logic [7:0] b, input logic kv,
                              input logic [8:0] lc, input logic [8:0] idx, input logic bitv);
    vec_t r;
    r.v = v; r.b = b; r.kv = kv; r.lc = lc; r.idx = idx; r.bitv = bitv;
    tbl.push_back(r);
  endfunction

  logic [7:0] alphabet [16];

  initial begin
    // Plain make, extended make/break, typematic repeats, Pause skipping, ignored bytes.
    add(1, 8'h75, 1, 9'h075, 9'h075, 1);
    add(1, 8'hE0, 0, 9'h075, 9'h075, 1);
    add(1, 8'h75, 1, 9'h175, 9'h175, 1);
    add(1, 8'hE0, 0, 9'h175, 9'h075, 1);
    add(1, 8'hF0, 0, 9'h175, 9'h175, 1);
    add(1, 8'h75, 1, 9'h175, 9'h175, 0);
    add(0, 8'h00, 0, 9'h175, 9'h075, 1);
    add(1, 8'h1D, 1, 9'h01D, 9'h01D, 1);
    add(1, 8'h1D, 0, 9'h01D, 9'h01D, 1);
    add(1, 8'h1D, 0, 9'h01D, 9'h01D, 1);
    add(1, 8'hF0, 0, 9'h01D, 9'h01D, 1);
    add(1, 8'h1D, 1, 9'h01D, 9'h01D, 0);
    add(1, 8'hE1, 0, 9'h01D, 9'h01D, 0);
    add(1, 8'h14, 0, 9'h01D, 9'h014, 0);
    add(1, 8'h77, 0, 9'h01D, 9'h077, 0);
    add(1, 8'hE1, 0, 9'h01D, 9'h0E1, 0);
    add(1, 8'hF0, 0, 9'h01D, 9'h01D, 0);
    add(1, 8'h14, 0, 9'h01D, 9'h014, 0);
    add(1, 8'hF0, 0, 9'h01D, 9'h01D, 0);
    add(1, 8'h77, 0, 9'h01D, 9'h077, 0);
    add(1, 8'h1C, 1, 9'h01C, 9'h01C, 1);
    add(1, 8'hAA, 0, 9'h01C, 9'h0AA, 0);
    add(1, 8'hFA, 0, 9'h01C, 9'h0FA, 0);
    add(1, 8'h00, 0, 9'h01C, 9'h000, 0);
    add(1, 8'hE0, 0, 9'h01C, 9'h01C, 1);
    add(1, 8'hE0, 0, 9'h01C, 9'h1E0, 0);
    add(1, 8'hE1, 0, 9'h01C, 9'h1E1, 0);
    add(1, 8'h1F, 1, 9'h11F, 9'h11F, 1);

    rst = 1'b1; rx_valid = 1'b0; rx_err = 1'b0; rx_byte = 8'h00;
    @(negedge clk);
    do_reset();

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].b, 1'b0);
      check($sformatf("tbl%0d_key_valid", i),   512'(key_valid),   512'(tbl[i].kv));
      check($sformatf("tbl%0d_last_change", i), 512'(last_change), 512'(tbl[i].lc));
      check($sformatf("tbl%0d_key_bit", i),     512'(key_down[tbl[i].idx]), 512'(tbl[i].bitv));
    end

    // Prefix survives a short gap, then is abandoned after a long one.
    do_reset();
    step(1, 8'hE0, 0);
    repeat (T_OUT - 1) step(0, 8'h00, 0);
    step(1, 8'h75, 0);
    check("gap15_make_ext", 512'(key_down[9'h175]), 512'(1));
    step(1, 8'hE0, 0);
    repeat (T_OUT + 1) step(0, 8'h00, 0);
    step(1, 8'h75, 0);
    check("timeout_kv",       512'(key_valid),         512'(1));
    check("timeout_lc",       512'(last_change),       512'(9'h075));
    check("timeout_plain",    512'(key_down[9'h075]), 512'(1));
    check("timeout_ext_kept", 512'(key_down[9'h175]), 512'(1));

    // Error with a byte drops the prefix; reset releases every key silently.
    do_reset();
    step(1, 8'hF0, 1);
    check("err_no_pulse", 512'(key_valid), 512'(0));
    step(1, 8'h75, 0);
    check("err_make_kv", 512'(key_valid),   512'(1));
    check("err_make_lc", 512'(last_change), 512'(9'h075));
    step(1, 8'h1D, 0);
    check("pre_rst_lc", 512'(last_change), 512'(9'h01D));
    do_reset();

    // Random streams biased toward a few keys so makes and breaks collide.
    alphabet = '{8'h75, 8'h1D, 8'h1C, 8'h6B, 8'h75, 8'h1D, 8'hE0, 8'hE0,
                 8'hF0, 8'hF0, 8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'h00, 8'h5A};
    for (int n = 0; n < 600; n++) begin
      logic [7:0] b;
      b = ($urandom_range(0, 19) == 0) ? 8'($urandom) : alphabet[$urandom_range(0, 15)];
      step(1'b1, b, ($urandom_range(0, 29) == 0));
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(T_OUT + 2, T_OUT + 8)) step(0, 8'h00, 0);
      end else begin
        repeat ($urandom_range(0, 3)) step(0, 8'h00, 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
